// File: rtl/f5_tt_pkg.sv
// ---------------------------------------------------------------------------
// f5_tt_pkg
// Shared constants for the truth-table sequencer:
//   - FSM state encoding (2 bits)
//   - maximum settle time and settle-counter width
// ---------------------------------------------------------------------------
package f5_tt_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_SAMPLE = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    // Longest settle time the 4-bit down-counter can time out.
    localparam int SETTLE_MAX = 15;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/f5_tt_settle_cnt.sv
// ---------------------------------------------------------------------------
// f5_tt_settle_cnt
// Loadable down-counter that times the settle interval of each vector.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset (counter -> 0)
//   load_i     load load_val_i (takes priority over dec_i)
//   dec_i      decrement by one; holds at zero
//   load_val_i value to load
//   zero_o     counter is zero
// ---------------------------------------------------------------------------
module f5_tt_settle_cnt
    import f5_tt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic             dec_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/f5_tt_sequencer.sv
// ---------------------------------------------------------------------------
// f5_tt_sequencer
// Drives every input combination onto a shared bus feeding two implementations
// of the same combinational function, waits SETTLE cycles per vector, samples
// both outputs, builds their truth-table columns and counts mismatches.
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-high reset; aborts a run
//   start      begin a run (honoured only in IDLE or DONE)
//   ya, yb     outputs of implementation A / B
//   x          input vector driven to both implementations
//   busy       high while a run is in progress (WAIT / SAMPLE)
//   done       one-cycle pulse when a run completes
//   pass       last completed run had no mismatches
//   err_count  number of mismatching vectors
//   first_fail index of the first mismatching vector (0 if none)
//   tt_a, tt_b sampled truth-table columns, bit i taken with x==i
// ---------------------------------------------------------------------------
module f5_tt_sequencer
    import f5_tt_pkg::*;
#(
    parameter int N_IN   = 2,
    parameter int SETTLE = 1      // legal range 1..SETTLE_MAX
)(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 ya,
    input  logic                 yb,
    output logic [N_IN-1:0]      x,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [N_IN:0]        err_count,
    output logic [N_IN-1:0]      first_fail,
    output logic [2**N_IN-1:0]   tt_a,
    output logic [2**N_IN-1:0]   tt_b
);

    localparam int NVEC = 2**N_IN;
    // Out-of-range settings are clamped so the counter load never wraps.
    localparam int SETTLE_C = (SETTLE < 1) ? 1 :
                              ((SETTLE > SETTLE_MAX) ? SETTLE_MAX : SETTLE);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_C - 1);
    localparam logic [N_IN-1:0]  IDX_LAST    = '1;
    localparam logic [N_IN-1:0]  IDX_INC     = 1;
    localparam logic [N_IN:0]    ERR_INC     = 1;

    logic [1:0]        state_q, state_d;
    // The vector index doubles as the driven x value: they are always equal.
    logic [N_IN-1:0]   idx_q, idx_d;
    logic [N_IN:0]     err_q, err_d;
    logic [N_IN-1:0]   ff_q, ff_d;
    logic [NVEC-1:0]   tta_q, tta_d;
    logic [NVEC-1:0]   ttb_q, ttb_d;
    logic              pass_q, pass_d;
    logic              busy_q, done_q;
    logic              cnt_load, cnt_dec, cnt_zero;

    f5_tt_settle_cnt u_settle (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load),
        .dec_i      (cnt_dec),
        .load_val_i (SETTLE_LOAD),
        .zero_o     (cnt_zero)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        err_d    = err_q;
        ff_d     = ff_q;
        tta_d    = tta_q;
        ttb_d    = ttb_q;
        pass_d   = pass_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d  = ST_WAIT;
                    idx_d    = '0;
                    err_d    = '0;
                    ff_d     = '0;
                    tta_d    = '0;
                    ttb_d    = '0;
                    pass_d   = 1'b0;
                    cnt_load = 1'b1;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_zero) state_d = ST_SAMPLE;
                else          cnt_dec = 1'b1;
            end
            ST_SAMPLE: begin
                tta_d[idx_q] = ya;
                ttb_d[idx_q] = yb;
                if (ya != yb) begin
                    err_d = err_q + ERR_INC;
                    if (err_q == '0) ff_d = idx_q;
                end
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                    // Include this last vector so pass is valid with done.
                    pass_d  = (err_d == '0);
                end else begin
                    idx_d    = idx_q + IDX_INC;
                    cnt_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= '0;
            ff_q    <= '0;
            tta_q   <= '0;
            ttb_q   <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            ff_q    <= ff_d;
            tta_q   <= tta_d;
            ttb_q   <= ttb_d;
            pass_q  <= pass_d;
            // Status flags are registered from the next state so they line
            // up exactly with the state they describe.
            busy_q  <= (state_d == ST_WAIT) || (state_d == ST_SAMPLE);
            done_q  <= (state_d == ST_DONE);
        end
    end

    assign x          = idx_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign err_count  = err_q;
    assign first_fail = ff_q;
    assign tt_a       = tta_q;
    assign tt_b       = ttb_q;

endmodule

// File: tb/tb_f5_tt_sequencer.sv
// ---------------------------------------------------------------------------
// tb_f5_tt_sequencer
// Two sequencer instances (SETTLE=1 and SETTLE=3, N_IN=2). Each pair of
// implementations under test is modelled as a 4-entry truth table:
// ya = fa[x], yb = fb[x].
// ---------------------------------------------------------------------------
module tb_f5_tt_sequencer;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       start1 = 1'b0, start3 = 1'b0;
    logic [3:0] fa1 = 4'b0, fb1 = 4'b0, fa3 = 4'b0, fb3 = 4'b0;
    logic [1:0] x1, x3, ff1, ff3;
    logic       busy1, busy3, done1, done3, pass1, pass3;
    logic [2:0] err1, err3;
    logic [3:0] tta1, tta3, ttb1, ttb3;
    logic       ya1, yb1, ya3, yb3;

    assign ya1 = fa1[x1];
    assign yb1 = fb1[x1];
    assign ya3 = fa3[x3];
    assign yb3 = fb3[x3];

    f5_tt_sequencer #(.N_IN(2), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .ya(ya1), .yb(yb1),
        .x(x1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
        .first_fail(ff1), .tt_a(tta1), .tt_b(ttb1)
    );

    f5_tt_sequencer #(.N_IN(2), .SETTLE(3)) dut3 (
        .clk(clk), .reset(reset), .start(start3), .ya(ya3), .yb(yb3),
        .x(x3), .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_fail(ff3), .tt_a(tta3), .tt_b(ttb3)
    );

    // Currently observed instance: 0 -> SETTLE=1, 1 -> SETTLE=3.
    logic       cur = 1'b0;
    logic [1:0] m_x, m_ff;
    logic       m_busy, m_done, m_pass;
    logic [2:0] m_err;
    logic [3:0] m_tta, m_ttb;
    always_comb begin
        m_x    = cur ? x3    : x1;
        m_ff   = cur ? ff3   : ff1;
        m_busy = cur ? busy3 : busy1;
        m_done = cur ? done3 : done1;
        m_pass = cur ? pass3 : pass1;
        m_err  = cur ? err3  : err1;
        m_tta  = cur ? tta3  : tta1;
        m_ttb  = cur ? ttb3  : ttb1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference: mismatch statistics straight from the two truth tables.
    function automatic void model(input logic [3:0] fa, input logic [3:0] fb,
                                  output logic [2:0] e, output logic [1:0] f,
                                  output logic p);
        e = 3'd0;
        f = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (fa[i] != fb[i]) begin
                if (e == 3'd0) f = i[1:0];
                e = e + 3'd1;
            end
        end
        p = (e == 3'd0);
    endfunction

    task automatic set_start(input logic v);
        if (cur) start3 = v; else start1 = v;
    endtask

    // One complete run: checks latency, x sequence, results and hold.
    task automatic run_check(input logic sel, input logic [3:0] fa, input logic [3:0] fb,
                             input logic [2:0] e_err, input logic [1:0] e_ff,
                             input logic e_pass, input string nm);
        int s;
        int lat;
        bit xok;
        cur = sel;
        s = sel ? 3 : 1;
        if (sel) begin fa3 = fa; fb3 = fb; end
        else     begin fa1 = fa; fb1 = fb; end
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk); #1;            // edge E0
        set_start(1'b0);
        xok = (m_x == 2'd0) && m_busy;
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (m_done) begin lat = k; break; end
            if (!m_busy || (int'(m_x) != k / (s + 1))) xok = 0;
        end
        $display("run %s sel=%0d fa=%b fb=%b lat=%0d tt_a=%b tt_b=%b err=%0d ff=%0d pass=%0d",
                 nm, sel, fa, fb, lat, m_tta, m_ttb, m_err, m_ff, m_pass);
        chk({nm, "_latency"}, lat, 4 * (s + 1));
        chk({nm, "_xseq"},    xok, 1);
        chk({nm, "_busy_done"}, m_busy, 0);
        chk({nm, "_tt_a"},    m_tta, fa);
        chk({nm, "_tt_b"},    m_ttb, fb);
        chk({nm, "_err"},     m_err, e_err);
        chk({nm, "_ff"},      m_ff, e_ff);
        chk({nm, "_pass"},    m_pass, e_pass);
        @(posedge clk); #1;
        chk({nm, "_done_pulse"}, m_done, 0);
        chk({nm, "_hold"}, {m_pass, m_err, m_ff, m_tta, m_ttb}, {e_pass, e_err, e_ff, fa, fb});
    endtask

    typedef struct {
        logic       sel;
        logic [3:0] fa;
        logic [3:0] fb;
        logic [2:0] err;
        logic [1:0] ff;
        logic       pass;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int k;
        logic [2:0] e_err;
        logic [1:0] e_ff;
        logic       e_pass;
        logic [3:0] ra, rb;

        // ~a&b is true only at x=1 (a=0,b=1) -> 4'b0010; a&b -> 4'b1000.
        tbl[0] = '{1'b0, 4'b0010, 4'b0010, 3'd0, 2'd0, 1'b1};
        tbl[1] = '{1'b0, 4'b0010, 4'b1000, 3'd2, 2'd1, 1'b0};
        tbl[2] = '{1'b1, 4'b0010, 4'b0010, 3'd0, 2'd0, 1'b1};
        tbl[3] = '{1'b0, 4'b0010, 4'b1101, 3'd4, 2'd0, 1'b0};
        tbl[4] = '{1'b1, 4'b0110, 4'b0111, 3'd1, 2'd0, 1'b0};
        tbl[5] = '{1'b0, 4'b1001, 4'b0001, 3'd1, 2'd3, 1'b0};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        cur = 1'b0;
        chk("reset_dut1", {x1, busy1, done1, pass1, err1, ff1, tta1, ttb1}, 0);
        chk("reset_dut3", {x3, busy3, done3, pass3, err3, ff3, tta3, ttb3}, 0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", {busy1, done1}, 0);

        // Table-driven runs
        for (int i = 0; i < 6; i++) begin
            run_check(tbl[i].sel, tbl[i].fa, tbl[i].fb, tbl[i].err, tbl[i].ff,
                      tbl[i].pass, $sformatf("tbl%0d", i));
        end

        // Reset during WAIT of vector 2 aborts the run
        cur = 1'b0; fa1 = 4'b0010; fb1 = 4'b0010;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        chk("abort_pre_x", x1, 2);
        chk("abort_pre_busy", busy1, 1);
        reset = 1'b1;
        #1;
        chk("abort_async", {x1, busy1, done1, pass1, err1, ff1, tta1, ttb1}, 0);
        @(posedge clk); #1;
        chk("abort_next_clk", {x1, busy1, done1, pass1, err1, ff1, tta1, ttb1}, 0);
        $display("abort x=%0d busy=%0d tt_a=%b", x1, busy1, tta1);
        @(negedge clk);
        reset = 1'b0;
        run_check(1'b0, 4'b0010, 4'b0010, 3'd0, 2'd0, 1'b1, "after_abort");

        // start pulsed mid-run, then held high through DONE
        cur = 1'b0; fa1 = 4'b0010; fb1 = 4'b1000;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;            // E0
        start1 = 1'b0;
        for (k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 3) start1 = 1'b1;
            if (k == 4) start1 = 1'b0;
            if (k == 7) start1 = 1'b1;
        end
        chk("b2b_done_lat", done1, 1);
        chk("b2b_first_err", err1, 2);
        chk("b2b_first_tta", tta1, 4'b0010);
        @(posedge clk); #1;            // start sampled in DONE
        $display("b2b restart x=%0d busy=%0d done=%0d err=%0d tt_a=%b", x1, busy1, done1, err1, tta1);
        chk("b2b_restart_busy", {busy1, done1}, 2'b10);
        chk("b2b_restart_clear", {x1, pass1, err1, ff1, tta1, ttb1}, 0);
        start1 = 1'b0;
        k = -1;
        for (int j = 1; j <= 40; j++) begin
            @(posedge clk); #1;
            if (done1) begin k = j; break; end
        end
        chk("b2b_second_lat", k, 8);
        chk("b2b_second_err", {err1, ff1, pass1}, {3'd2, 2'd1, 1'b0});

        // Randomized runs against the reference model
        for (int r = 0; r < 12; r++) begin
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? ra : 4'($urandom_range(0, 15));
            model(ra, rb, e_err, e_ff, e_pass);
            run_check(1'($urandom_range(0, 1)), ra, rb, e_err, e_ff, e_pass,
                      $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/f5_tt_sequencer.md
Name: f5_tt_sequencer

Overview:
- Sequencer that runs the truth-table check the team's combinational gate modules are verified by, such as the gate-level and expression forms of ~a & b.
- It drives every input combination onto a shared input bus feeding two implementations (A and B) of the same function, waits a programmable settle time, and samples both outputs.
- It builds each implementation's truth-table column, counts mismatches and reports pass/fail.
- It replaces hand-written #1 stimulus sequences with a clocked, reusable controller, usable in simulation and as a Logisim-style on-board checker.

Parameters:
- N_IN, 2, number of function inputs; the sequencer applies 2**N_IN vectors.
- SETTLE, 1, wait cycles per vector between drive and sample; legal range 1..15.

Ports:
- clk  input  1  single system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a run; sampled only in IDLE or DONE
- ya  input  1  output of implementation A
- yb  input  1  output of implementation B
- x  output  N_IN  vector driven to both implementations; x[N_IN-1] is the leftmost input (a), x[0] is the rightmost (b)
- busy  output  1  high in WAIT and SAMPLE
- done  output  1  one-cycle pulse when a run completes
- pass  output  1  high when the last completed run had err_count==0; valid from done onward
- err_count  output  N_IN+1  number of mismatching vectors in the current or last run
- first_fail  output  N_IN  index of the first mismatching vector; 0 if none
- tt_a  output  2**N_IN  bit i = ya sampled with x==i
- tt_b  output  2**N_IN  bit i = yb sampled with x==i

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, x=0, busy=0, done=0, pass=0, err_count=0, first_fail=0, tt_a=0, tt_b=0, idx=0, cnt=0. Reset asserted mid-run aborts immediately; no partial results are retained.
- States and transitions:
  - IDLE: on start=1, x<=0, idx<=0, cnt<=SETTLE-1, and err_count, first_fail, tt_a, tt_b and pass all clear; go to WAIT.
  - WAIT: if cnt==0 go to SAMPLE, else cnt<=cnt-1. This gives exactly SETTLE cycles with x stable before sampling.
  - SAMPLE: tt_a[idx]<=ya and tt_b[idx]<=yb.
    - If ya!=yb: err_count<=err_count+1, and first_fail<=idx when err_count==0.
    - If idx==2**N_IN-1: go to DONE. Otherwise idx<=idx+1, x<=idx+1, cnt<=SETTLE-1, go to WAIT.
  - DONE: done=1 for this cycle only; pass=(err_count==0).
    - start=1 here begins a new run, same as in IDLE.
    - Otherwise go to IDLE.
- Outputs are registered. Results (pass, err_count, first_fail, tt_a, tt_b) hold until the next start.
- Latency: with start sampled at edge E0, vector i is sampled at edge E0+(i+1)*(SETTLE+1). done is high in the cycle after edge E0+2**N_IN*(SETTLE+1). For N_IN=2, SETTLE=1, that is the cycle after E0+8.
- start while busy is ignored. start held high continuously runs back-to-back with one DONE cycle between runs.
- err_count cannot overflow: its maximum is 2**N_IN, which fits in N_IN+1 bits.
- x never leaves the range 0..2**N_IN-1. There is no wrap within a run.

Decomposition:
- Shared package f5_tt_pkg holds:
  - the state encoding constants ST_IDLE=0, ST_WAIT=1, ST_SAMPLE=2, ST_DONE=3, in 2 bits;
  - the SETTLE_MAX=15 limit.
- One sub-module, f5_tt_settle_cnt: a loadable 4-bit down-counter with load and zero flag, used for the WAIT timing.
- The FSM, index register and result registers stay in the top module.

Test Plan:
- Both implementations are ~a&b (ya=yb=~x[1]&x[0]), N_IN=2, SETTLE=1, pulse start -> done in the cycle after E0+8, tt_a=tt_b=4'b0010, err_count=0, first_fail=0, pass=1.
- ya=~x[1]&x[0], yb=x[1]&x[0] -> tt_a=4'b0010, tt_b=4'b1000, err_count=2, first_fail=1, pass=0.
- SETTLE=3, identical implementations -> x holds each value for 4 cycles; done in the cycle after E0+16; pass=1.
- Assert reset during WAIT of vector 2 -> all outputs 0 and state IDLE on the next clock. A fresh start then gives a clean run with pass=1.
- start pulsed while busy, plus start held high through DONE -> mid-run pulse ignored (done still in the cycle after E0+8). Second run begins from DONE with results cleared, x=0 on the following cycle.
- yb=~ya for all vectors -> err_count=4 (3'b100, no overflow), first_fail=0, pass=0.
